// File: rtl/data_sram_like_responder.sv
// Responder end of the data_sram req/addr_ok/data_ok bus: an internal word RAM
// answered in order, a fixed DELAY cycles after each request is accepted.
module data_sram_like_responder #(
  parameter int MEM_AW = 10,
  parameter int DELAY  = 2,
  parameter int QDEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  input  logic        addr_stall,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);
  localparam logic [2:0] QD    = 3'(QDEPTH);
  localparam logic [3:0] TLOAD = 4'(DELAY - 1);

  logic [31:0]       r_mem [2**MEM_AW];
  logic [2:0]        r_count;
  logic [1:0]        r_wptr;
  logic [1:0]        r_rptr;
  logic [3:0]        r_q_valid;
  logic [3:0]        r_q_wr;
  logic [31:0]       r_q_rdata [4];
  logic [3:0]        r_q_timer [4];
  logic              r_data_ok;
  logic [31:0]       r_rdata;

  logic [MEM_AW-1:0] w_idx;
  logic [31:0]       w_rd_word;
  logic              w_accept;
  logic              w_retire;
  logic              w_mature;
  logic [31:0]       w_mature_rdata;
  logic              w_next_ok;
  logic [31:0]       w_next_rdata;
  logic              w_unused;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    if (p == 2'(QDEPTH - 1)) begin
      return 2'd0;
    end else begin
      return p + 2'd1;
    end
  endfunction

  assign w_idx             = data_sram_addr[MEM_AW+1:2];
  assign w_rd_word         = r_mem[w_idx];
  assign data_sram_addr_ok = data_sram_req & ~addr_stall & (r_count < QD) & ~reset;
  assign w_accept          = data_sram_req & data_sram_addr_ok;
  // The registered data_ok pulse is the head entry leaving the queue.
  assign w_retire          = r_data_ok;
  assign data_sram_data_ok = r_data_ok;
  assign data_sram_rdata   = r_rdata;
  assign w_unused          = ^{data_sram_size, data_sram_addr[31:MEM_AW+2], data_sram_addr[1:0]};

  // Find the entry whose response must be presented next cycle (timer about to reach zero).
  always_comb begin
    w_mature       = 1'b0;
    w_mature_rdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (r_q_valid[i] && (r_q_timer[i] == 4'd1)) begin
        w_mature       = 1'b1;
        w_mature_rdata = r_q_wr[i] ? 32'h0 : r_q_rdata[i];
      end else begin
        w_mature       = w_mature;
        w_mature_rdata = w_mature_rdata;
      end
    end
  end

  // With a one-cycle latency the response comes straight from the accepted request.
  always_comb begin
    w_next_ok    = 1'b0;
    w_next_rdata = 32'h0;
    if (DELAY == 1) begin
      w_next_ok    = w_accept;
      w_next_rdata = (w_accept && !data_sram_wr) ? w_rd_word : 32'h0;
    end else begin
      w_next_ok    = w_mature;
      w_next_rdata = w_mature_rdata;
    end
  end

  // Byte-masked RAM write; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_accept && data_sram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_wstrb[b]) begin
          r_mem[w_idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
        end
      end
    end
  end

  // Entry payload and latency timers.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (r_q_valid[i] && (r_q_timer[i] != 4'd0)) begin
        r_q_timer[i] <= r_q_timer[i] - 4'd1;
      end
    end
    if (w_accept) begin
      r_q_timer[r_wptr] <= TLOAD;
      r_q_wr[r_wptr]    <= data_sram_wr;
      r_q_rdata[r_wptr] <= w_rd_word;
    end
  end

  // Queue occupancy, pointers and registered response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count   <= 3'd0;
      r_wptr    <= 2'd0;
      r_rptr    <= 2'd0;
      r_q_valid <= 4'd0;
      r_data_ok <= 1'b0;
      r_rdata   <= 32'h0;
    end else begin
      r_data_ok <= w_next_ok;
      r_rdata   <= w_next_rdata;
      if (w_retire) begin
        r_q_valid[r_rptr] <= 1'b0;
        r_rptr            <= ptr_inc(r_rptr);
      end
      if (w_accept) begin
        r_q_valid[r_wptr] <= 1'b1;
        r_wptr            <= ptr_inc(r_wptr);
      end
      case ({w_accept, w_retire})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: tb/tb_data_sram_like_responder.sv
// Directed bench for data_sram_like_responder: one stimulus stream feeds a DELAY=2 and a
// DELAY=1 instance; a cycle-level model checks both, literal checks pin the model.
module tb_data_sram_like_responder;
  logic        clk = 1'b0;
  logic        reset, req, wr, stall;
  logic [3:0]  wstrb;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        ao2, do2, ao1, do1;
  logic [31:0] rd2, rd1;
  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;

  bit          exp_ok  [2][0:2047];
  logic [31:0] exp_dat [2][0:2047];
  bit          acc     [2][0:2047];
  logic [31:0] mmem    [2][0:1023];
  int          last_rst [2];

  always #5 clk = ~clk;

  data_sram_like_responder #(.MEM_AW(10), .DELAY(2), .QDEPTH(2)) u_d2 (
    .clk(clk), .reset(reset), .data_sram_req(req), .data_sram_wr(wr),
    .data_sram_wstrb(wstrb), .data_sram_size(size), .data_sram_addr(addr),
    .data_sram_wdata(wdata), .addr_stall(stall), .data_sram_addr_ok(ao2),
    .data_sram_data_ok(do2), .data_sram_rdata(rd2));

  data_sram_like_responder #(.MEM_AW(10), .DELAY(1), .QDEPTH(2)) u_d1 (
    .clk(clk), .reset(reset), .data_sram_req(req), .data_sram_wr(wr),
    .data_sram_wstrb(wstrb), .data_sram_size(size), .data_sram_addr(addr),
    .data_sram_wdata(wdata), .addr_stall(stall), .data_sram_addr_ok(ao1),
    .data_sram_data_ok(do1), .data_sram_rdata(rd1));

  function automatic int dly(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  // Requests still owed a response in cycle c: accepted after the last reset, within DELAY cycles.
  function automatic int outstanding(input int k, input int c);
    int n = 0;
    for (int a = c - dly(k); a < c; a++) begin
      if (a >= 0 && a > last_rst[k] && acc[k][a]) n++;
    end
    return n;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (DELAY=%0d) cyc=%0d got=%h want=%h", nm, dly(k), cyc, act, exp);
    end
  endtask

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  // Model-based compare on every cycle, then advance the model with this cycle's inputs.
  initial begin
    last_rst[0] = -100;
    last_rst[1] = -100;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        logic        e_ao, a_ao, a_do;
        logic [31:0] a_rd;
        int          w;
        a_ao = (k == 0) ? ao2 : ao1;
        a_do = (k == 0) ? do2 : do1;
        a_rd = (k == 0) ? rd2 : rd1;
        e_ao = req && !stall && !reset && (outstanding(k, cyc) < 2);
        if (cyc >= 1) begin
          chk("addr_ok", k, 32'(a_ao), 32'(e_ao));
          chk("data_ok", k, 32'(a_do), 32'(exp_ok[k][cyc]));
          chk("rdata", k, a_rd, exp_ok[k][cyc] ? exp_dat[k][cyc] : 32'h0);
        end
        if (e_ao) begin
          w = int'(addr[11:2]);
          exp_ok[k][cyc + dly(k)]  = 1'b1;
          exp_dat[k][cyc + dly(k)] = wr ? 32'h0 : mmem[k][w];
          acc[k][cyc] = 1'b1;
          if (wr) begin
            for (int b = 0; b < 4; b++) begin
              if (wstrb[b]) mmem[k][w][8*b +: 8] = wdata[8*b +: 8];
            end
          end
        end
        if (reset) begin
          last_rst[k] = cyc;
          for (int d = 1; d <= 16; d++) exp_ok[k][cyc + d] = 1'b0;
        end
      end
      cyc++;
    end
  end

  task automatic step(input logic r, input logic rq, input logic w, input logic [3:0] st,
                      input logic [31:0] a, input logic [31:0] d, input logic s);
    @(posedge clk);
    #1;
    reset = r; req = rq; wr = w; wstrb = st; addr = a; wdata = d; stall = s;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic lw(input logic [31:0] a, input logic s);
    step(1'b0, 1'b1, 1'b0, 4'h0, a, 32'h0, s);
  endtask

  task automatic sw(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
    step(1'b0, 1'b1, 1'b1, st, a, d, 1'b0);
  endtask

  logic [31:0] t6_addr [6];
  logic [31:0] t6_data [6];

  initial begin
    reset = 1'b1; req = 1'b0; wr = 1'b0; wstrb = 4'h0; size = 2'd2;
    addr = 32'h0; wdata = 32'h0; stall = 1'b0;
    t6_addr = '{32'h10, 32'h40, 32'h10, 32'h40, 32'h10, 32'h40};
    t6_data = '{32'h12AA5678, 32'hCAFEF00D, 32'h12AA5678, 32'hCAFEF00D, 32'h12AA5678, 32'hCAFEF00D};

    step(1'b1, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0);
    lit("rst_addr_ok", 32'(ao2), 32'h0);
    lit("rst_data_ok", 32'(do2), 32'h0);
    lit("rst_rdata", rd2, 32'h0);
    idle();

    // full-word write then read back
    sw(32'h10, 32'h12345678, 4'hF); lit("t1_sw_acc", 32'(ao2), 32'h1);
    lw(32'h10, 1'b0);               lit("t1_lw_acc", 32'(ao2), 32'h1);
    idle(); lit("t1_wr_ok", 32'(do2), 32'h1); lit("t1_wr_rdata", rd2, 32'h0);
    idle(); lit("t1_rd_ok", 32'(do2), 32'h1); lit("t1_rd_rdata", rd2, 32'h12345678);
    idle(); lit("t1_quiet", 32'(do2), 32'h0);

    // byte write, then an all-strobes-off write that must change nothing
    sw(32'h12, 32'hAAAAAAAA, 4'b0100);
    idle();
    sw(32'h10, 32'hFFFFFFFF, 4'b0000);
    idle();
    lw(32'h10, 1'b0);
    idle();
    idle(); lit("t2_ok", 32'(do2), 32'h1); lit("t2_rdata", rd2, 32'h12AA5678);
    idle();
    idle();

    // held read requests against a two-deep queue
    lw(32'h10, 1'b0); lit("t3_acc0", 32'(ao2), 32'h1);
    lw(32'h10, 1'b0); lit("t3_acc1", 32'(ao2), 32'h1);
    lw(32'h10, 1'b0); lit("t3_full", 32'(ao2), 32'h0); lit("t3_ok0", 32'(do2), 32'h1);
    lw(32'h10, 1'b0); lit("t3_acc2", 32'(ao2), 32'h1); lit("t3_ok1", 32'(do2), 32'h1);
    idle(); lit("t3_gap", 32'(do2), 32'h0);
    idle(); lit("t3_ok2", 32'(do2), 32'h1); lit("t3_rdata", rd2, 32'h12AA5678);
    idle();
    idle();

    // addr_stall held for four cycles
    for (int i = 0; i < 4; i++) begin
      lw(32'h10, 1'b1);
      lit("t4_stall_addr_ok", 32'(ao2), 32'h0);
      lit("t4_stall_data_ok", 32'(do2), 32'h0);
    end
    lw(32'h10, 1'b0); lit("t4_release", 32'(ao2), 32'h1);
    idle();
    idle(); lit("t4_ok", 32'(do2), 32'h1); lit("t4_rdata", rd2, 32'h12AA5678);
    idle();

    // reset discards an outstanding read; RAM keeps its contents
    sw(32'h40, 32'hCAFEF00D, 4'hF);
    idle();
    idle();
    idle();
    lw(32'h40, 1'b0); lit("t5_acc", 32'(ao2), 32'h1);
    step(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    idle(); lit("t5_drop0", 32'(do2), 32'h0);
    idle(); lit("t5_drop1", 32'(do2), 32'h0);
    lw(32'h40, 1'b0); lit("t5_reacc", 32'(ao2), 32'h1);
    idle();
    idle(); lit("t5_ok", 32'(do2), 32'h1); lit("t5_rdata", rd2, 32'hCAFEF00D);
    idle();
    idle();

    // single-cycle latency: one read per cycle, continuous in-order responses
    for (int i = 0; i < 6; i++) begin
      lw(t6_addr[i], 1'b0);
      lit("t6_acc", 32'(ao1), 32'h1);
      if (i > 0) begin
        lit("t6_ok", 32'(do1), 32'h1);
        lit("t6_rdata", rd1, t6_data[i-1]);
      end
    end
    idle(); lit("t6_ok_last", 32'(do1), 32'h1); lit("t6_rdata_last", rd1, t6_data[5]);
    idle(); lit("t6_quiet", 32'(do1), 32'h0);
    idle();
    idle();
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
